conv1_window_gen: RTL

Streaming 3×3 window generator feeding the layer-1 convolution engine. It accepts one 32-bit pixel per cycle in raster order, buffers the two previous image rows, and emits every fully-populated 3×3 window as nine parallel words with a one-cycle valid strobe. It sits between the input-image source and the conv1 calculation block, which consumes one window per cycle with no backpressure. With no padding and stride 1, a 28×28 frame produces 26×26 = 676 windows.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_line_buffer.sv | 43 ++++
 rtl/conv1_window_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the layer-1 convolution datapath.
package conv_pkg;

  localparam int unsigned IMG_W  = 28;
  localparam int unsigned IMG_H  = 28;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KERNEL = 3;
  localparam int unsigned TAPS   = KERNEL * KERNEL;
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned COL_W  = $clog2(IMG_W);

  typedef logic [DATA_W-1:0] pixel_t;

  // Nine taps, row-major, oldest row first: element 0 is top-left.
  typedef logic [TAPS-1:0][DATA_W-1:0] window_t;

endpackage : conv_pkg

// File: rtl/conv_line_buffer.sv
// Enable-driven delay line: rd_data_o is the word written DEPTH enables ago.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately left unreset; the slot at ptr_q is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[ptr_q];

endmodule : conv_line_buffer

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one registered window per completing pixel out.
module conv1_window_gen
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  pixel_t           pix_in,
  input  logic             pix_valid,
  output window_t          data_out,
  output logic             valid_out,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
);

  logic             accept;
  pixel_t           lb0_out;
  pixel_t           lb1_out;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  window_t          sr_q, sr_d;
  window_t          data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  // A pixel presented during reset is dropped, so it must not disturb the line buffers either.
  assign accept = pix_valid & ~rst;

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) u_lb0 (
    .clk       (clk),
    .rst       (rst),
    .en_i      (accept),
    .wr_data_i (pix_in),
    .rd_data_o (lb0_out)
  );

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) u_lb1 (
    .clk       (clk),
    .rst       (rst),
    .en_i      (accept),
    .wr_data_i (lb0_out),
    .rd_data_o (lb1_out)
  );

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    win_row_d = win_row_q;
    win_col_d = win_col_q;

    if (accept) begin
      // Shift left one column; the new right column is {row r-2, row r-1, row r}.
      sr_d[0] = sr_q[1];
      sr_d[1] = sr_q[2];
      sr_d[2] = lb1_out;
      sr_d[3] = sr_q[4];
      sr_d[4] = sr_q[5];
      sr_d[5] = lb0_out;
      sr_d[6] = sr_q[7];
      sr_d[7] = sr_q[8];
      sr_d[8] = pix_in;

      if ((row_q >= ROW_W'(KERNEL - 1)) && (col_q >= COL_W'(KERNEL - 1))) begin
        valid_d   = 1'b1;
        data_d    = sr_d;
        win_row_d = row_q - ROW_W'(KERNEL - 1);
        win_col_d = col_q - COL_W'(KERNEL - 1);
        done_d    = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
      end

      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule : conv1_window_gen
